// File: rtl/jogador_automatico.sv
// Automatic player: captures a one-hot LED sequence shown by the game, waits for
// the display to go quiet, then replays it as timed button presses.
module jogador_automatico #(
  parameter int unsigned MAX_SEQ   = 16,
  parameter int unsigned T_QUIET   = 100,
  parameter int unsigned T_PRESS   = 10,
  parameter int unsigned T_RELEASE = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] leds,
  input  logic       fim_jogo,
  input  logic       errar,
  output logic [3:0] botoes,
  output logic       jogando,
  output logic       erro_captura,
  output logic [3:0] db_contagem,
  output logic [3:0] db_estado
);

  localparam int unsigned QW   = (T_QUIET > 1) ? $clog2(T_QUIET) : 1;
  localparam int unsigned TMAX = (T_PRESS > T_RELEASE) ? T_PRESS : T_RELEASE;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [QW-1:0] QUIET_LAST = QW'(T_QUIET - 1);
  localparam logic [TW-1:0] PRESS_LAST = TW'(T_PRESS - 1);
  localparam logic [TW-1:0] REL_LAST   = TW'(T_RELEASE - 1);
  localparam logic [4:0]    SEQ_MAX    = 5'(MAX_SEQ);

  typedef enum logic [3:0] {
    OCIOSO     = 4'h0,
    ESPERA_LED = 4'h1,
    SILENCIO   = 4'h2,
    PRESSIONA  = 4'h3,
    SOLTA      = 4'h4,
    ERRO       = 4'hE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    leds_ant_q;
  logic [4:0]    count_q, count_d;
  logic [3:0]    idx_q, idx_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    botoes_q, botoes_d;
  logic          jogando_q, jogando_d;
  logic          erro_q, erro_d;
  logic [3:0]    mem_q [0:15];
  logic          mem_we_s;
  logic          capture_s;

  function automatic logic is_one_hot(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

  // The deliberate mistake is the stored pattern rotated left by one position.
  function automatic logic [3:0] press_value(input logic [3:0] p, input logic wrong);
    return wrong ? {p[2:0], p[3]} : p;
  endfunction

  assign capture_s = (leds != 4'd0) && (leds_ant_q == 4'd0);

  // Next-state, counters and the value the registered outputs take at the next edge.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    quiet_d  = quiet_q;
    timer_d  = timer_q;
    botoes_d = botoes_q;
    mem_we_s = 1'b0;

    if (fim_jogo && (state_q != OCIOSO)) begin
      state_d  = OCIOSO;
      count_d  = 5'd0;
      idx_d    = 4'd0;
      quiet_d  = '0;
      timer_d  = '0;
      botoes_d = 4'b0000;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (habilita) begin
            state_d = ESPERA_LED;
            count_d = 5'd0;
            idx_d   = 4'd0;
            quiet_d = '0;
            timer_d = '0;
          end else begin
            state_d = OCIOSO;
          end
        end
        ESPERA_LED, SILENCIO: begin
          if (capture_s) begin
            if ((count_q == SEQ_MAX) || !is_one_hot(leds)) begin
              state_d = ERRO;
            end else begin
              mem_we_s = 1'b1;
              count_d  = count_q + 5'd1;
              quiet_d  = '0;
              state_d  = SILENCIO;
            end
          end else if (state_q == SILENCIO) begin
            if (leds != 4'd0) begin
              quiet_d = '0;
            end else if (quiet_q == QUIET_LAST) begin
              state_d  = PRESSIONA;
              idx_d    = 4'd0;
              timer_d  = '0;
              botoes_d = press_value(mem_q[0], errar && (count_q == 5'd1));
            end else begin
              quiet_d = quiet_q + QW'(1);
            end
          end else begin
            state_d = state_q;
          end
        end
        PRESSIONA: begin
          if (timer_q == PRESS_LAST) begin
            state_d  = SOLTA;
            timer_d  = '0;
            botoes_d = 4'b0000;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        SOLTA: begin
          if (timer_q == REL_LAST) begin
            timer_d = '0;
            if (({1'b0, idx_q} + 5'd1) < count_q) begin
              idx_d    = idx_q + 4'd1;
              state_d  = PRESSIONA;
              botoes_d = press_value(mem_q[idx_q + 4'd1],
                                     errar && (({1'b0, idx_q} + 5'd2) == count_q));
            end else begin
              state_d = ESPERA_LED;
              count_d = 5'd0;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ERRO: begin
          state_d  = ERRO;
          botoes_d = 4'b0000;
        end
        default: begin
          state_d  = OCIOSO;
          botoes_d = 4'b0000;
        end
      endcase
    end

    jogando_d = (state_d == PRESSIONA) || (state_d == SOLTA);
    erro_d    = (state_d == ERRO);
  end

  // State, counters, LED history and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= OCIOSO;
      leds_ant_q <= 4'd0;
      count_q    <= 5'd0;
      idx_q      <= 4'd0;
      quiet_q    <= '0;
      timer_q    <= '0;
      botoes_q   <= 4'd0;
      jogando_q  <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      leds_ant_q <= leds;
      count_q    <= count_d;
      idx_q      <= idx_d;
      quiet_q    <= quiet_d;
      timer_q    <= timer_d;
      botoes_q   <= botoes_d;
      jogando_q  <= jogando_d;
      erro_q     <= erro_d;
    end
  end

  // Sequence storage; stale entries are harmless because count gates every read.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[count_q[3:0]] <= leds;
    end
  end

  assign botoes       = botoes_q;
  assign jogando      = jogando_q;
  assign erro_captura = erro_q;
  assign db_contagem  = count_q[3:0] - 4'd1;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: directed scenarios plus random traffic, all
// compared each cycle against a queue-based behavioural model.
module tb_jogador_automatico;

  localparam int MAX_SEQ   = 4;
  localparam int T_QUIET   = 4;
  localparam int T_PRESS   = 2;
  localparam int T_RELEASE = 2;

  logic       clock, reset, habilita, fim_jogo, errar;
  logic [3:0] leds, botoes, db_contagem, db_estado;
  logic       jogando, erro_captura;

  int n_vec = 0;
  int n_err = 0;

  jogador_automatico #(
    .MAX_SEQ(MAX_SEQ), .T_QUIET(T_QUIET), .T_PRESS(T_PRESS), .T_RELEASE(T_RELEASE)
  ) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .leds(leds),
    .fim_jogo(fim_jogo), .errar(errar), .botoes(botoes), .jogando(jogando),
    .erro_captura(erro_captura), .db_contagem(db_contagem), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: idle, listening (collecting the sequence), replaying a precomputed
  // per-cycle button stream, or stuck in error.
  typedef enum int {M_IDLE, M_LISTEN, M_REPLAY, M_ERR} mode_t;
  mode_t      m_mode;
  logic [3:0] m_seq[$];
  logic [3:0] m_play[$];
  logic [3:0] m_prev;
  int         m_quiet;

  task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_seq.delete();
    m_play.delete();
    m_prev = 4'd0;
    m_quiet = 0;
  endtask

  task automatic start_replay(input logic err);
    logic [3:0] p;
    m_mode = M_REPLAY;
    m_play.delete();
    for (int i = 0; i < m_seq.size(); i++) begin
      p = m_seq[i];
      if (err && (i == m_seq.size() - 1)) p = {p[2:0], p[3]};
      repeat (T_PRESS) m_play.push_back(p);
      repeat (T_RELEASE) m_play.push_back(4'd0);
    end
  endtask

  task automatic model_step(input logic hab, input logic [3:0] l, input logic fim, input logic err);
    logic cap;
    cap = (l != 4'd0) && (m_prev == 4'd0);
    if (m_mode != M_IDLE && fim) begin
      m_mode = M_IDLE;
      m_seq.delete();
      m_play.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (hab) begin
          m_mode = M_LISTEN;
          m_seq.delete();
          m_quiet = 0;
        end
        M_LISTEN: begin
          if (cap) begin
            if (m_seq.size() == MAX_SEQ || $countones(l) != 1) m_mode = M_ERR;
            else begin
              m_seq.push_back(l);
              m_quiet = 0;
            end
          end else if (m_seq.size() > 0) begin
            if (l != 4'd0) m_quiet = 0;
            else begin
              m_quiet++;
              if (m_quiet == T_QUIET) start_replay(err);
            end
          end
        end
        M_REPLAY: begin
          void'(m_play.pop_front());
          if (m_play.size() == 0) begin
            m_mode = M_LISTEN;
            m_seq.delete();
          end
        end
        default: ;
      endcase
    end
    m_prev = l;
  endtask

  task automatic compare_all();
    logic [3:0] eb, es, ec;
    eb = (m_mode == M_REPLAY) ? m_play[0] : 4'd0;
    case (m_mode)
      M_IDLE:   es = 4'h0;
      M_LISTEN: es = (m_seq.size() == 0) ? 4'h1 : 4'h2;
      M_REPLAY: es = (m_play[0] != 4'd0) ? 4'h3 : 4'h4;
      default:  es = 4'hE;
    endcase
    ec = 4'(m_seq.size() - 1);
    chk_eq("botoes", {4'd0, botoes}, {4'd0, eb});
    chk_eq("jogando", {7'd0, jogando}, {7'd0, m_mode == M_REPLAY});
    chk_eq("erro_captura", {7'd0, erro_captura}, {7'd0, m_mode == M_ERR});
    chk_eq("db_estado", {4'd0, db_estado}, {4'd0, es});
    chk_eq("db_contagem", {4'd0, db_contagem}, {4'd0, ec});
  endtask

  // Entered at a negedge; drives inputs, clocks once, checks, returns at the next negedge.
  task automatic step(input logic hab, input logic [3:0] l, input logic fim, input logic err);
    habilita = hab; leds = l; fim_jogo = fim; errar = err;
    @(posedge clock);
    model_step(hab, l, fim, err);
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic run(input logic hab, input logic [3:0] l, input logic err, input int n);
    repeat (n) step(hab, l, 1'b0, err);
  endtask

  task automatic async_reset();
    #1 reset = 1'b0;
    #1;
    chk_eq("rst_botoes", {4'd0, botoes}, 8'd0);
    chk_eq("rst_jogando", {7'd0, jogando}, 8'd0);
    chk_eq("rst_erro", {7'd0, erro_captura}, 8'd0);
    chk_eq("rst_estado", {4'd0, db_estado}, 8'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic       seen;
    logic [3:0] cur;
    logic       err_r;
    int         hold, r;

    reset = 1'b0; habilita = 1'b0; leds = 4'd0; fim_jogo = 1'b0; errar = 1'b0;
    model_reset();
    #2;
    chk_eq("reset_botoes", {4'd0, botoes}, 8'd0);
    chk_eq("reset_estado", {4'd0, db_estado}, 8'd0);
    chk_eq("reset_contagem", {4'd0, db_contagem}, 8'h0F);
    chk_eq("reset_jogando", {7'd0, jogando}, 8'd0);
    @(negedge clock);
    reset = 1'b1;

    // Round trip
    run(1'b1, 4'b0000, 1'b0, 1);
    run(1'b1, 4'b0001, 1'b0, 3);
    run(1'b1, 4'b0000, 1'b0, 2);
    run(1'b1, 4'b0100, 1'b0, 3);
    run(1'b1, 4'b0000, 1'b0, 14);
    chk_eq("roundtrip_contagem", {4'd0, db_contagem}, 8'h0F);

    // Deliberate error on the last press
    run(1'b1, 4'b0010, 1'b1, 2);
    run(1'b1, 4'b0000, 1'b1, 1);
    run(1'b1, 4'b1000, 1'b1, 2);
    run(1'b1, 4'b0000, 1'b1, 14);

    // Invalid pattern, then fim_jogo
    run(1'b1, 4'b0011, 1'b0, 1);
    chk_eq("invalid_erro", {7'd0, erro_captura}, 8'd1);
    chk_eq("invalid_estado", {4'd0, db_estado}, 8'h0E);
    run(1'b1, 4'b0000, 1'b0, 3);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    chk_eq("fim_erro", {7'd0, erro_captura}, 8'd0);

    // Overflow on the fifth capture
    run(1'b1, 4'b0000, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 4'b0001 << (i % 4), 1'b0, 1);
      run(1'b1, 4'b0000, 1'b0, 1);
    end
    chk_eq("overflow_estado", {4'd0, db_estado}, 8'h0E);
    step(1'b1, 4'b0000, 1'b1, 1'b0);

    // LEDs during replay are ignored, held pattern is not captured afterwards
    run(1'b1, 4'b0000, 1'b0, 1);
    run(1'b1, 4'b0001, 1'b0, 1);
    run(1'b1, 4'b0000, 1'b0, 4);
    run(1'b1, 4'b1000, 1'b0, 7);
    run(1'b1, 4'b0000, 1'b0, 1);
    run(1'b1, 4'b0001, 1'b0, 1);
    chk_eq("recapture_contagem", {4'd0, db_contagem}, 8'd0);

    // Asynchronous reset mid-press
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    run(1'b1, 4'b0000, 1'b0, 1);
    run(1'b1, 4'b0100, 1'b0, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      if (botoes == 4'b0100) seen = 1'b1;
    end
    chk_eq("press_0100_seen", {7'd0, seen}, 8'd1);
    async_reset();

    // Random traffic
    cur = 4'd0; hold = 0; err_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 99);
        if (r < 55) cur = 4'd0;
        else if (r < 93) cur = 4'b0001 << $urandom_range(0, 3);
        else cur = 4'($urandom_range(1, 15));
        hold = $urandom_range(1, 6);
      end
      hold--;
      if (m_mode != M_REPLAY && $urandom_range(0, 19) == 0) err_r = ~err_r;
      if ($urandom_range(0, 699) == 0) async_reset();
      else step($urandom_range(0, 7) != 0, cur, $urandom_range(0, 79) == 0, err_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
